// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared PS/2 definitions: receiver state encodings, frame geometry and
// the break-code constant that the downstream display stage also keys on.
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;
  localparam logic [PS2_DATA_BITS-1:0] PS2_BREAK_CODE = 8'hF0;

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    DATA   = 4'b0010,
    PARITY = 4'b0100,
    STOP   = 4'b1000
  } ps2_state_e;

  // Odd parity: the data bits plus the parity bit must hold an odd number of ones.
  function automatic logic frame_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx_if
// Bundles the raw PS/2 lines and the received-byte outputs of ps2_frame_rx.
//   ps2_clk, ps2_data : raw, asynchronous PS/2 lines (driven by the device side)
//   rx_data           : last good byte
//   rx_recFlag        : one-cycle strobe, rx_data new in that cycle
//   rx_err            : one-cycle strobe on parity/stop/timeout error
//   err_cnt           : saturating error count
//   busy              : frame in progress
// master = line driver / byte consumer, slave = the receiver.
// ---------------------------------------------------------------------------
interface ps2_frame_rx_if;
  import ps2_pkg::*;

  logic                     ps2_clk;
  logic                     ps2_data;
  logic [PS2_DATA_BITS-1:0] rx_data;
  logic                     rx_recFlag;
  logic                     rx_err;
  logic [7:0]               err_cnt;
  logic                     busy;

  modport master (
    output ps2_clk, ps2_data,
    input  rx_data, rx_recFlag, rx_err, err_cnt, busy
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output rx_data, rx_recFlag, rx_err, err_cnt, busy
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
// Multi-stage synchronizers for the raw PS/2 clock and data lines plus a
// falling-edge detector on the synchronized clock.
//   clk, rst_n    : system clock, async active-low reset
//   ps2_clk_raw   : raw PS/2 clock
//   ps2_data_raw  : raw PS/2 data
//   data_sync     : synchronized data
//   fall          : one-cycle strobe, synchronized clock went 1 -> 0
// All flops reset to 1 (idle bus) so releasing reset never fakes an edge.
// ---------------------------------------------------------------------------
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_raw,
  input  logic ps2_data_raw,
  output logic data_sync,
  output logic fall
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_raw};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data_raw};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign data_sync = data_sync_q[SYNC_STAGES-1];
  assign fall      = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
// PS/2 device-to-host frame receiver. Deserializes start, 8 data bits
// (LSB first), odd parity and stop; commits good bytes with a one-cycle
// strobe, drops and counts malformed or stalled frames.
//   clk      : system clock
//   rst      : asynchronous, active-low reset
//   bus      : ps2_frame_rx_if.slave (raw lines in, byte/status out)
// Parameters:
//   TIMEOUT_CYCLES : idle clk cycles inside a frame before it is abandoned
//   SYNC_STAGES    : synchronizer depth, >= 2
//
// state  | meaning
// IDLE   | waiting for a start bit (data=0 at a falling edge)
// DATA   | shifting in the 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking stop bit and parity, commit or flag error
// ---------------------------------------------------------------------------
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic          clk,
  input  logic          rst,
  ps2_frame_rx_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam int BW = $clog2(PS2_DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(PS2_DATA_BITS - 1);

  logic data_s;
  logic fall;

  ps2_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk          (clk),
    .rst_n        (rst),
    .ps2_clk_raw  (bus.ps2_clk),
    .ps2_data_raw (bus.ps2_data),
    .data_sync    (data_s),
    .fall         (fall)
  );

  ps2_state_e               state_q, state_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic                     parity_q, parity_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [PS2_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                     rec_q, rec_d;
  logic                     err_q, err_d;
  logic [7:0]               err_cnt_q, err_cnt_d;
  logic                     busy_q, busy_d;
  logic                     timeout;
  logic                     error_evt;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    rx_data_d = rx_data_q;
    err_cnt_d = err_cnt_q;
    rec_d     = 1'b0;
    err_d     = 1'b0;
    error_evt = 1'b0;

    // Down-counter reloads on every edge and while idle; a falling edge in the
    // terminal cycle reloads it, so the edge always beats the timeout.
    if (state_q == IDLE || fall) begin
      timer_d = TO_LOAD;
    end else if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end else begin
      timer_d = timer_q;
    end
    timeout = (state_q != IDLE) && !fall && (timer_q == '0);

    case (state_q)
      IDLE: begin
        if (fall && !data_s) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {data_s, shift_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = data_s;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (data_s && frame_parity_ok(shift_q, parity_q)) begin
            rx_data_d = shift_q;
            rec_d     = 1'b1;
          end else begin
            error_evt = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      error_evt = 1'b1;
      state_d   = IDLE;
    end

    if (error_evt) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      timer_q   <= TO_LOAD;
      rx_data_q <= '0;
      rec_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      timer_q   <= timer_d;
      rx_data_q <= rx_data_d;
      rec_q     <= rec_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_recFlag = rec_q;
  assign bus.rx_err     = err_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

PS/2 device-to-host frame receiver: synchronizes the raw `ps2_clk`/`ps2_data` lines, deserializes 11-bit frames (start, 8 data LSB-first, odd parity, stop), and presents each good byte with a one-cycle strobe. It sits directly upstream of the keyboard display stage; `rx_data`/`rx_recFlag` connect straight to that stage's `ps2dis_data`/`ps2dis_recFlag`. Malformed or stalled frames are dropped, flagged, and counted.

## Interface
- `TIMEOUT_CYCLES`, default 50000: clk cycles without a `ps2_clk` falling edge before an in-progress frame is abandoned.
- `SYNC_STAGES`, default 2: flop stages in each input synchronizer, minimum 2.

- `clk`  in  1  system clock; all logic in this single domain.
- `rst`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock line, asynchronous.
- `ps2_data`  in  1  raw PS/2 data line, asynchronous.
- `rx_data`  out  8  last correctly received byte; holds between frames.
- `rx_recFlag`  out  1  one-cycle pulse; `rx_data` is new in that cycle.
- `rx_err`  out  1  one-cycle pulse on parity, stop, or timeout error.
- `err_cnt`  out  8  saturating error count.
- `busy`  out  1  high while a frame is in progress (state != IDLE).

## Operation
- Reset values: `rx_data`=0x00, `rx_recFlag`=0, `rx_err`=0, `err_cnt`=0, `busy`=0, state=IDLE, synchronizer flops=1 (idle bus), so reset release cannot create a false edge.
- Edge strobe `fall`: synchronized ps2_clk previous=1, current=0. All line sampling uses synchronized `ps2_data` in the `fall` cycle only.
- States, one-hot: IDLE 4'b0001, DATA 4'b0010, PARITY 4'b0100, STOP 4'b1000.
  - IDLE: `fall` with data=0 goes to DATA, clearing bit count and shift register. `fall` with data=1 is ignored silently: no error, stay in IDLE.
  - DATA: each `fall` shifts the bit in LSB-first. On the 8th bit, go to PARITY.
  - PARITY: `fall` latches the parity bit and goes to STOP.
  - STOP: on `fall`, if stop=1 and the 8 data bits plus parity hold an odd count of ones, commit: update `rx_data` and pulse `rx_recFlag`. Otherwise pulse `rx_err`, increment `err_cnt`, and leave `rx_data` unchanged. Both paths return to IDLE.
- Timeout: a cycle counter runs only outside IDLE and is cleared on every `fall`. When it reaches `TIMEOUT_CYCLES`, pulse `rx_err`, increment `err_cnt`, and go to IDLE. If `fall` and the terminal count occur in the same cycle, `fall` wins and no timeout fires.
- `err_cnt` saturates at 255 and never wraps.
- `rx_recFlag` and `rx_err` are never high in the same cycle.
- Reset asserted mid-frame: everything returns to reset values immediately and the partial frame is discarded. The next frame needs a fresh start bit.

## Timing
- Input to `fall` latency: `SYNC_STAGES`+1 clk after the raw falling edge.
- `rx_recFlag`, `rx_data`, `rx_err`, and `err_cnt` all update on the clk edge following the `fall` cycle of the stop bit, or the terminal-count cycle for a timeout. The pulse lasts exactly one cycle.
- `busy` rises the cycle after the start-bit `fall` and falls in the same cycle as the `rx_recFlag`/`rx_err` pulse.
- Back-to-back frames are supported: IDLE can accept a start bit in the cycle right after returning.
- Requirement: the clk period must be at most 1/4 of the minimum PS/2 clock low/high time (≥30 µs).

## Structure
- Shared package `ps2_pkg`:
  - state encodings: IDLE, DATA, PARITY, STOP.
  - `PS2_DATA_BITS`=8.
  - `PS2_BREAK_CODE`=8'hF0, also used by the display stage.
- Sub-module `ps2_sync_edge`: `SYNC_STAGES` synchronizer on both lines, plus a falling-edge detector on the clock. It outputs synchronized data and the `fall` strobe.

## Test plan
- Frame 0x1C, parity 0, stop 1 → one `rx_recFlag` pulse with `rx_data`=0x1C; `err_cnt`=0.
- Frames 0x1C, 0xF0 (parity 1), 0x1C back-to-back → exactly three pulses carrying 0x1C, 0xF0, 0x1C in order; `busy` low between frames.
- After a good 0x1C: send 0x23 with parity flipped, then 0x23 with stop=0 → two `rx_err` pulses, `err_cnt`=2, no `rx_recFlag`, `rx_data` stays 0x1C.
- `TIMEOUT_CYCLES`=100: stop `ps2_clk` after 4 data bits → `rx_err` exactly 100 clk after the last `fall`, `busy`=0. A following 0x32 frame is received correctly.
- Assert `rst` after 5 data bits → all outputs at reset values. After release, a 0x45 frame gives `rx_data`=0x45; `ps2_data` high at a `fall` in IDLE gives no error.
- 260 parity-bad frames → `err_cnt` holds 255; the next good 0x1C still strobes.
